// File: rtl/ntt_loop_controller.sv
`default_nettype none
// ============================================================================
// ntt_loop_controller : stage/group/address sequencer for a two-BFU radix-2 NTT
// Revision 1.0
// ============================================================================
module ntt_loop_controller #(
    parameter int LOGN = 10,
    parameter int CW   = 8,
    parameter int GAP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      conf,
    input  logic            hold,
    output logic [2:0]      conf_out,
    output logic [3:0]      p,
    output logic [CW-1:0]   k,
    output logic [LOGN-1:0] addr_a0,
    output logic [LOGN-1:0] addr_b0,
    output logic [LOGN-1:0] addr_a1,
    output logic [LOGN-1:0] addr_b1,
    output logic            valid,
    output logic            busy,
    output logic            done
);

    localparam int              GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0]   C_LAST   = '1;
    localparam logic [3:0]      P_TOP    = 4'(LOGN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   c;
    logic [GW-1:0]   gcnt;

    logic            fwd_in;
    logic            fwd_run;
    logic            last_stage;
    logic [3:0]      p_step;
    logic            ld;
    logic [3:0]      ld_p;
    logic [CW-1:0]   ld_c;
    logic [CW-1:0]   ld_k;
    logic [LOGN:0]   b0;
    logic [LOGN:0]   b1;
    logic [LOGN-1:0] half;
    logic [LOGN-1:0] ld_a0;
    logic [LOGN-1:0] ld_b0;
    logic [LOGN-1:0] ld_a1;
    logic [LOGN-1:0] ld_b1;

    // Insert a zero at bit position sh of b: the top-of-pair address.
    function automatic logic [LOGN-1:0] top_of(input logic [LOGN:0] b, input logic [3:0] sh);
        logic [LOGN:0] lo_mask;
        logic [LOGN:0] hi;
        lo_mask = ~({(LOGN+1){1'b1}} << sh);
        hi      = (b >> sh) << (sh + 4'd1);
        return LOGN'(hi | (b & lo_mask));
    endfunction

    // Select the (stage, counter) pair to be presented on the next load.
    always_comb begin
        fwd_in     = (conf == 3'b001) || (conf == 3'b100);
        fwd_run    = (conf_out == 3'b001) || (conf_out == 3'b100);
        last_stage = fwd_run ? (p == 4'd0) : (p == P_TOP);
        p_step     = fwd_run ? (p - 4'd1) : (p + 4'd1);
        ld         = 1'b0;
        ld_p       = p;
        ld_c       = c + 1'b1;
        case (state)
            ST_IDLE: begin
                ld   = start;
                ld_p = fwd_in ? P_TOP : 4'd0;
                ld_c = '0;
            end
            ST_RUN: begin
                if (c == C_LAST) begin
                    ld   = !last_stage && (GAP == 0);
                    ld_p = p_step;
                    ld_c = '0;
                end else begin
                    ld = 1'b1;
                end
            end
            ST_GAP: begin
                ld   = (gcnt == GAP_LAST);
                ld_p = p_step;
                ld_c = '0;
            end
            default: ;
        endcase
    end

    // Stage 0 splits the counter range across the BFUs; other stages pair 2c/2c+1.
    always_comb begin
        half = {{(LOGN-1){1'b0}}, 1'b1} << ld_p;
        if (ld_p == 4'd0) begin
            b0   = (LOGN+1)'(ld_c);
            b1   = (LOGN+1)'({1'b1, ld_c});
            ld_k = ld_c;
        end else begin
            b0   = (LOGN+1)'({ld_c, 1'b0});
            b1   = b0 | (LOGN+1)'(1);
            ld_k = CW'({ld_c, 1'b0} >> ld_p);
        end
        ld_a0 = top_of(b0, ld_p);
        ld_a1 = top_of(b1, ld_p);
        ld_b0 = ld_a0 + half;
        ld_b1 = ld_a1 + half;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            c        <= '0;
            gcnt     <= '0;
            conf_out <= 3'd0;
            p        <= 4'd0;
            k        <= '0;
            addr_a0  <= '0;
            addr_b0  <= '0;
            addr_a1  <= '0;
            addr_b1  <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (!hold) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        conf_out <= conf;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (c == C_LAST) begin
                        if (last_stage) begin
                            state <= ST_FIN;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (GAP > 0) begin
                            state <= ST_GAP;
                            valid <= 1'b0;
                            gcnt  <= '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gcnt == GAP_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            if (ld) begin
                valid   <= 1'b1;
                p       <= ld_p;
                c       <= ld_c;
                k       <= ld_k;
                addr_a0 <= ld_a0;
                addr_b0 <= ld_b0;
                addr_a1 <= ld_a1;
                addr_b1 <= ld_b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ntt_loop_controller.sv
`default_nettype none
// ============================================================================
// tb_ntt_loop_controller : self-checking bench for ntt_loop_controller
// Revision 1.0
// ============================================================================
module tb_ntt_loop_controller;

    localparam int LOGN    = 10;
    localparam int CW      = 8;
    localparam int GAP     = 4;
    localparam int NC      = 1 << CW;
    localparam int N       = 1 << LOGN;
    localparam int RUN_LEN = LOGN * NC + (LOGN - 1) * GAP;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            hold;
    logic [2:0]      conf;
    logic [2:0]      conf_out;
    logic [3:0]      p;
    logic [CW-1:0]   k;
    logic [LOGN-1:0] a0, b0, a1, b1;
    logic            valid, busy, done;

    ntt_loop_controller #(.LOGN(LOGN), .CW(CW), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .start(start), .conf(conf), .hold(hold),
        .conf_out(conf_out), .p(p), .k(k),
        .addr_a0(a0), .addr_b0(b0), .addr_a1(a1), .addr_b1(b1),
        .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit valid; bit busy; bit done;
        int p; int c; int k; int a0; int b0; int a1; int b1;
    } exp_t;

    typedef struct { int p; int c; int k; int a0; int b0; int a1; int b1; } vec_t;

    exp_t seq[$];
    exp_t rec[LOGN][NC];
    bit   recd[LOGN][NC];
    vec_t vt[8];
    int   total = 0;
    int   bad   = 0;

    function automatic int top_of(int b, int h);
        return (b / h) * 2 * h + (b % h);
    endfunction

    function automatic exp_t pair(int pp, int cc);
        exp_t r;
        int h, bb0, bb1;
        h = 2 ** pp;
        if (pp >= 1) begin
            bb0 = 2 * cc; bb1 = 2 * cc + 1; r.k = ((2 * cc) / h) % NC;
        end else begin
            bb0 = cc; bb1 = cc + NC; r.k = cc;
        end
        r.valid = 1; r.busy = 1; r.done = 0; r.p = pp; r.c = cc;
        r.a0 = top_of(bb0, h) % N; r.b0 = (top_of(bb0, h) + h) % N;
        r.a1 = top_of(bb1, h) % N; r.b1 = (top_of(bb1, h) + h) % N;
        return r;
    endfunction

    task automatic build_seq(input logic [2:0] cf);
        exp_t g;
        bit fwd;
        fwd = (cf == 3'b001) || (cf == 3'b100);
        seq.delete();
        g = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int s = 0; s < LOGN; s++) begin
            for (int cc = 0; cc < NC; cc++) seq.push_back(pair(fwd ? LOGN - 1 - s : s, cc));
            if (s < LOGN - 1) for (int gi = 0; gi < GAP; gi++) seq.push_back(g);
        end
        g.busy = 0; g.done = 1;
        seq.push_back(g);
    endtask

    task automatic chk(input exp_t e, input logic [2:0] cf);
        bit ok;
        total++;
        ok = (valid === e.valid) && (busy === e.busy) && (done === e.done) && (conf_out === cf);
        if (e.valid)
            ok = ok && (p === 4'(e.p)) && (k === CW'(e.k)) && (a0 === LOGN'(e.a0)) &&
                 (b0 === LOGN'(e.b0)) && (a1 === LOGN'(e.a1)) && (b1 === LOGN'(e.b1));
        if (!ok) begin
            bad++;
            $display("FAIL cycle p=%0d c=%0d: got v=%0d bz=%0d d=%0d cf=%0d p=%0d k=%0d a=%0d/%0d/%0d/%0d want v=%0d bz=%0d d=%0d cf=%0d k=%0d a=%0d/%0d/%0d/%0d",
                     e.p, e.c, valid, busy, done, conf_out, p, k, a0, b0, a1, b1,
                     e.valid, e.busy, e.done, cf, e.k, e.a0, e.b0, e.a1, e.b1);
        end
    endtask

    task automatic chk_zero(input string tag);
        total++;
        if (valid !== 0 || busy !== 0 || done !== 0 || conf_out !== 0 || p !== 0 ||
            k !== 0 || a0 !== 0 || b0 !== 0 || a1 !== 0 || b1 !== 0) begin
            bad++;
            $display("FAIL %s: got v=%0d bz=%0d d=%0d cf=%0d p=%0d k=%0d a=%0d/%0d/%0d/%0d want all zero",
                     tag, valid, busy, done, conf_out, p, k, a0, b0, a1, b1);
        end
    endtask

    task automatic run_transform(input logic [2:0] cf, input int hold_pct, input int hold_at,
                                 input int hold_len, input int spur_at, input int abort_idx);
        int idx, cyc, nhold, done_cyc;
        exp_t d;
        build_seq(cf);
        @(negedge clk); conf = cf; start = 1; hold = 0;
        @(negedge clk); start = 0; conf = 3'($urandom);
        idx = 0; cyc = 0; nhold = 0; done_cyc = -1;
        while (idx < seq.size() && idx != abort_idx && cyc < 20000) begin
            chk(seq[idx], cf);
            if (seq[idx].valid && valid) begin
                d = seq[idx];
                d.k = int'(k); d.a0 = int'(a0); d.b0 = int'(b0); d.a1 = int'(a1); d.b1 = int'(b1);
                rec[seq[idx].p][seq[idx].c] = d;
                recd[seq[idx].p][seq[idx].c] = 1;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            hold = (cyc >= hold_at && cyc < hold_at + hold_len) || ($urandom_range(99) < hold_pct);
            start = (cyc == spur_at);
            if (start) conf = ~cf;
            if (hold && idx < seq.size() - 1) nhold++;
            @(negedge clk); start = 0;
            if (!hold) idx++;
            cyc++;
        end
        hold = 0;
        if (cyc >= 20000) begin
            total++; bad++;
            $display("FAIL timeout: got %0d cycles without completion, required <20000", cyc);
        end else if (abort_idx < 0) begin
            total++;
            if (valid !== 0 || busy !== 0 || done !== 0) begin
                bad++;
                $display("FAIL post_idle: got v=%0d bz=%0d d=%0d required 0/0/0", valid, busy, done);
            end
            total++;
            if (done_cyc != RUN_LEN + nhold) begin
                bad++;
                $display("FAIL run_length: got %0d required %0d", done_cyc, RUN_LEN + nhold);
            end
        end
    endtask

    initial begin
        vt[0] = '{9, 0,   0, 0,   512,  1,   513};
        vt[1] = '{0, 3,   3, 6,   7,    518, 519};
        vt[2] = '{4, 37,  4, 138, 154,  139, 155};
        vt[3] = '{9, 255, 0, 510, 1022, 511, 1023};
        vt[4] = '{1, 5,   5, 20,  22,   21,  23};
        vt[5] = '{0, 255, 255, 510, 511, 1022, 1023};
        vt[6] = '{5, 100, 6, 392, 424,  393, 425};
        vt[7] = '{0, 0,   0, 0,   1,    512, 513};

        rst = 1; start = 0; hold = 0; conf = 3'd0;
        #12 rst = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); conf = 3'($urandom);
            chk_zero("idle_after_reset");
        end

        run_transform(3'b001, 0, -1, 0, -1, -1);
        run_transform(3'b100, 0, 100, 10, 500, -1);
        run_transform(3'b010, 0, -1, 0, -1, -1);
        run_transform(3'($urandom), 10, -1, 0, 1200, -1);
        run_transform(3'($urandom), 15, 2000, 7, -1, -1);

        // Abort a forward run inside the gap that follows stage 5.
        run_transform(3'b001, 0, -1, 0, -1, 1297);
        #2 rst = 1;
        #1 chk_zero("async_reset");
        @(negedge clk); @(negedge clk); rst = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_zero("after_abort");
        end
        run_transform(3'b010, 0, -1, 0, -1, -1);

        for (int i = 0; i < 8; i++) begin
            total++;
            if (!recd[vt[i].p][vt[i].c] || rec[vt[i].p][vt[i].c].k != vt[i].k ||
                rec[vt[i].p][vt[i].c].a0 != vt[i].a0 || rec[vt[i].p][vt[i].c].b0 != vt[i].b0 ||
                rec[vt[i].p][vt[i].c].a1 != vt[i].a1 || rec[vt[i].p][vt[i].c].b1 != vt[i].b1) begin
                bad++;
                $display("FAIL vector p=%0d c=%0d: got seen=%0d k=%0d a=%0d/%0d/%0d/%0d required k=%0d a=%0d/%0d/%0d/%0d",
                         vt[i].p, vt[i].c, recd[vt[i].p][vt[i].c], rec[vt[i].p][vt[i].c].k,
                         rec[vt[i].p][vt[i].c].a0, rec[vt[i].p][vt[i].c].b0,
                         rec[vt[i].p][vt[i].c].a1, rec[vt[i].p][vt[i].c].b1,
                         vt[i].k, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
